// File: rtl/ball_pkg.sv
// Shared types and constants for the ball motion controller.
package ball_pkg;

    typedef enum logic [1:0] {
        WAIT_LAUNCH,
        MOVING,
        LOST
    } ball_state_t;

    // Bit positions within hitEdgeCode and the sticky hit-flag vector
    localparam int EDGE_TOP    = 3;
    localparam int EDGE_BOTTOM = 2;
    localparam int EDGE_LEFT   = 1;
    localparam int EDGE_RIGHT  = 0;

    localparam int FIXED_POINT_SHIFT = 6;

endpackage

// File: rtl/ball_move_ctrl.sv
// Frame-rate ball motion controller: fixed-point position, edge reflection from
// sticky collision flags, launch handshake and loss detection below the screen.
module ball_move_ctrl #(
    parameter int INITIAL_X         = 280,
    parameter int INITIAL_Y         = 400,
    parameter int INITIAL_X_SPEED   = 64,
    parameter int INITIAL_Y_SPEED   = -128,
    parameter int FIXED_POINT_SHIFT = ball_pkg::FIXED_POINT_SHIFT,
    parameter int SCREEN_BOTTOM     = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               launch,
    input  logic               collision,
    input  logic [3:0]         hitEdgeCode,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               moving,
    output logic               ballLost
);
    import ball_pkg::*;

    localparam int PIX_W = 11;
    localparam int VEL_W = 11;
    localparam int POS_W = PIX_W + FIXED_POINT_SHIFT;

    localparam logic signed [POS_W-1:0] INIT_POS_X = POS_W'(INITIAL_X * (2 ** FIXED_POINT_SHIFT));
    localparam logic signed [POS_W-1:0] INIT_POS_Y = POS_W'(INITIAL_Y * (2 ** FIXED_POINT_SHIFT));
    localparam logic signed [VEL_W-1:0] INIT_VX    = VEL_W'(INITIAL_X_SPEED);
    localparam logic signed [VEL_W-1:0] INIT_VY    = VEL_W'(INITIAL_Y_SPEED);

    ball_state_t             state;
    logic signed [POS_W-1:0] posX, posY;
    logic signed [VEL_W-1:0] vx, vy;
    logic [3:0]              hit_flags;

    logic [3:0]              hit_in;
    logic signed [VEL_W-1:0] vx_next, vy_next;
    logic signed [POS_W-1:0] posX_adv, posY_adv;
    logic signed [PIX_W-1:0] topLeftY_adv;

    // Integer part of the fixed-point position; slicing equals an arithmetic shift
    assign topLeftX = posX[POS_W-1:FIXED_POINT_SHIFT];
    assign topLeftY = posY[POS_W-1:FIXED_POINT_SHIFT];

    assign hit_in = collision ? hitEdgeCode : 4'b0000;

    // Reflection only flips a velocity that points into the side that was hit,
    // so repeated or wrong-direction hits within one frame cannot double-invert.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        vx_next = vx;
        vy_next = vy;
        if ((hit_flags[EDGE_TOP] && (vy < 0)) || (hit_flags[EDGE_BOTTOM] && (vy > 0)))
            vy_next = -vy;
        if ((hit_flags[EDGE_LEFT] && (vx < 0)) || (hit_flags[EDGE_RIGHT] && (vx > 0)))
            vx_next = -vx;
        posX_adv     = posX + {{(POS_W-VEL_W){vx_next[VEL_W-1]}}, vx_next};
        posY_adv     = posY + {{(POS_W-VEL_W){vy_next[VEL_W-1]}}, vy_next};
        topLeftY_adv = posY_adv[POS_W-1:FIXED_POINT_SHIFT];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_LAUNCH;
            posX      <= INIT_POS_X;
            posY      <= INIT_POS_Y;
            vx        <= INIT_VX;
            vy        <= INIT_VY;
            hit_flags <= 4'b0000;
            moving    <= 1'b0;
            ballLost  <= 1'b0;
        end else begin
            case (state)
                WAIT_LAUNCH: begin
                    posX      <= INIT_POS_X;
                    posY      <= INIT_POS_Y;
                    vx        <= INIT_VX;
                    vy        <= INIT_VY;
                    hit_flags <= 4'b0000;
                    ballLost  <= 1'b0;
                    if (startOfFrame && launch) begin
                        state  <= MOVING;
                        moving <= 1'b1;
                    end
                end

                MOVING: begin
                    if (startOfFrame) begin
                        vx        <= vx_next;
                        vy        <= vy_next;
                        posX      <= posX_adv;
                        posY      <= posY_adv;
                        // A hit coincident with the frame tick lands after the clear
                        hit_flags <= hit_in;
                        if (int'(topLeftY_adv) >= SCREEN_BOTTOM) begin
                            state    <= LOST;
                            moving   <= 1'b0;
                            ballLost <= 1'b1;
                        end
                    end else begin
                        hit_flags <= hit_flags | hit_in;
                    end
                end

                LOST: begin
                    posX      <= INIT_POS_X;
                    posY      <= INIT_POS_Y;
                    vx        <= INIT_VX;
                    vy        <= INIT_VY;
                    hit_flags <= 4'b0000;
                    moving    <= 1'b0;
                    ballLost  <= 1'b0;
                    state     <= WAIT_LAUNCH;
                end

                default: begin
                    state     <= WAIT_LAUNCH;
                    hit_flags <= 4'b0000;
                    moving    <= 1'b0;
                    ballLost  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_move_ctrl.sv
// Self-checking bench for ball_move_ctrl: directed scenarios plus randomized
// traffic compared against a pixel/unit-level behavioural model.
module tb_ball_move_ctrl;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               launch = 1'b0;
    logic               collision = 1'b0;
    logic [3:0]         hitEdgeCode = 4'b0000;
    logic signed [10:0] topLeftX, topLeftY;
    logic               moving, ballLost;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ball_move_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .launch       (launch),
        .collision    (collision),
        .hitEdgeCode  (hitEdgeCode),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .moving       (moving),
        .ballLost     (ballLost)
    );

    // Behavioural model: position in 1/64-pixel units, modes as plain ints
    localparam int M_IDLE = 0;
    localparam int M_FLY  = 1;
    localparam int M_GONE = 2;

    int         m_px, m_py, m_vx, m_vy, m_mode;
    logic [3:0] m_hit;

    function automatic int wrap17(input int v);
        int r;
        r = ((v % 131072) + 131072) % 131072;
        return (r >= 65536) ? r - 131072 : r;
    endfunction

    function automatic int neg11(input int v);
        return (v == -1024) ? -1024 : -v;
    endfunction

    task automatic model_reset();
        m_px   = 280 * 64;
        m_py   = 400 * 64;
        m_vx   = 64;
        m_vy   = -128;
        m_hit  = 4'b0000;
        m_mode = M_IDLE;
    endtask

    task automatic model_step();
        logic [3:0] h;
        h = collision ? hitEdgeCode : 4'b0000;
        case (m_mode)
            M_IDLE: if (startOfFrame && launch) m_mode = M_FLY;
            M_FLY: begin
                if (startOfFrame) begin
                    if ((m_hit[3] && m_vy < 0) || (m_hit[2] && m_vy > 0)) m_vy = neg11(m_vy);
                    if ((m_hit[1] && m_vx < 0) || (m_hit[0] && m_vx > 0)) m_vx = neg11(m_vx);
                    m_px  = wrap17(m_px + m_vx);
                    m_py  = wrap17(m_py + m_vy);
                    m_hit = h;
                    if ((m_py >>> 6) >= 480) m_mode = M_GONE;
                end else begin
                    m_hit = m_hit | h;
                end
            end
            default: model_reset();
        endcase
    endtask

    // One clock: model follows the same edge, outputs sampled 1 time unit later
    task automatic clk_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        clk_step();
        startOfFrame = 1'b0;
    endtask

    task automatic hit_cycle(input logic [3:0] code);
        collision   = 1'b1;
        hitEdgeCode = code;
        clk_step();
        collision   = 1'b0;
        hitEdgeCode = 4'b0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (topLeftX !== 11'sd280) begin n_fail++; $display("FAIL reset_x got=%0d want=280", topLeftX); end
        n_checks++;
        if (topLeftY !== 11'sd400) begin n_fail++; $display("FAIL reset_y got=%0d want=400", topLeftY); end
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving got=%b want=0", moving); end
        n_checks++;
        if (ballLost !== 1'b0) begin n_fail++; $display("FAIL reset_lost got=%b want=0", ballLost); end
        reset = 1'b0;
    endtask

    task automatic test_launch();
        launch = 1'b1;
        frame();
        launch = 1'b0;
        n_checks++;
        if ({moving, topLeftX, topLeftY} !== {1'b1, 11'sd280, 11'sd400}) begin
            n_fail++; $display("FAIL launch got mv=%b x=%0d y=%0d want mv=1 x=280 y=400", moving, topLeftX, topLeftY);
        end
        repeat (3) clk_step();
        n_checks++;
        if ({topLeftX, topLeftY} !== {11'sd280, 11'sd400}) begin
            n_fail++; $display("FAIL stable_between_frames got x=%0d y=%0d want 280/400", topLeftX, topLeftY);
        end
        frame();
        n_checks++;
        if ({topLeftX, topLeftY} !== {11'sd281, 11'sd398}) begin
            n_fail++; $display("FAIL first_move got x=%0d y=%0d want 281/398", topLeftX, topLeftY);
        end
    endtask

    task automatic test_top_bounce();
        hit_cycle(4'b1000);
        clk_step();
        frame();
        n_checks++;
        if ({topLeftX, topLeftY} !== {11'sd282, 11'sd400}) begin
            n_fail++; $display("FAIL top_bounce got x=%0d y=%0d want 282/400", topLeftX, topLeftY);
        end
    endtask

    task automatic test_repeated_hits();
        // Bottom hit turns the ball upward again so a top hit can act
        hit_cycle(4'b0100);
        frame();
        n_checks++;
        if (topLeftY !== 11'sd398) begin n_fail++; $display("FAIL bottom_bounce got y=%0d want 398", topLeftY); end
        repeat (3) hit_cycle(4'b1000);
        frame();
        n_checks++;
        if ({topLeftX, topLeftY} !== {11'sd284, 11'sd400}) begin
            n_fail++; $display("FAIL triple_hit got x=%0d y=%0d want 284/400", topLeftX, topLeftY);
        end
        hit_cycle(4'b1000);
        frame();
        n_checks++;
        if (topLeftY !== 11'sd402) begin n_fail++; $display("FAIL wrong_dir_hit got y=%0d want 402", topLeftY); end
    endtask

    task automatic test_coincident();
        startOfFrame = 1'b1;
        collision    = 1'b1;
        hitEdgeCode  = 4'b0100;
        clk_step();
        startOfFrame = 1'b0;
        collision    = 1'b0;
        hitEdgeCode  = 4'b0000;
        n_checks++;
        if (topLeftY !== 11'sd404) begin n_fail++; $display("FAIL coincident_same got y=%0d want 404", topLeftY); end
        clk_step();
        frame();
        n_checks++;
        if ({topLeftX, topLeftY} !== {11'sd287, 11'sd402}) begin
            n_fail++; $display("FAIL coincident_next got x=%0d y=%0d want 287/402", topLeftX, topLeftY);
        end
    endtask

    task automatic test_loss();
        int  frames;
        bit  seen;
        hit_cycle(4'b1000);
        frames = 0;
        seen   = 1'b0;
        // y=402 falling 2 px per frame reaches 480 after 39 frames
        while (!seen && frames < 100) begin
            frame();
            frames++;
            if (ballLost === 1'b1) seen = 1'b1;
            else clk_step();
        end
        n_checks++;
        if (!seen || frames != 39) begin
            n_fail++; $display("FAIL loss_frame got seen=%0d frames=%0d want seen=1 frames=39", seen, frames);
        end
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL loss_moving got=%b want=0", moving); end
        clk_step();
        n_checks++;
        if ({ballLost, moving, topLeftX, topLeftY} !== {1'b0, 1'b0, 11'sd280, 11'sd400}) begin
            n_fail++; $display("FAIL after_loss got lost=%b mv=%b x=%0d y=%0d want 0/0/280/400",
                               ballLost, moving, topLeftX, topLeftY);
        end
        frame();
        n_checks++;
        if ({moving, topLeftY} !== {1'b0, 11'sd400}) begin
            n_fail++; $display("FAIL wait_without_launch got mv=%b y=%0d want 0/400", moving, topLeftY);
        end
    endtask

    task automatic test_mid_reset();
        launch = 1'b1;
        frame();
        launch = 1'b0;
        frame();
        hit_cycle(4'b1000);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({moving, ballLost, topLeftX, topLeftY} !== {1'b0, 1'b0, 11'sd280, 11'sd400}) begin
            n_fail++; $display("FAIL async_reset got mv=%b lost=%b x=%0d y=%0d want 0/0/280/400",
                               moving, ballLost, topLeftX, topLeftY);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        launch = 1'b1;
        frame();
        launch = 1'b0;
        frame();
        n_checks++;
        if ({topLeftX, topLeftY} !== {11'sd281, 11'sd398}) begin
            n_fail++; $display("FAIL no_stale_bounce got x=%0d y=%0d want 281/398", topLeftX, topLeftY);
        end
    endtask

    task automatic test_random();
        int errs;
        logic signed [10:0] e_x, e_y;
        errs = 0;
        for (int i = 0; i < 4000; i++) begin
            startOfFrame = ($urandom_range(0, 3) == 0);
            launch       = ($urandom_range(0, 1) == 1);
            collision    = ($urandom_range(0, 2) == 0);
            hitEdgeCode  = 4'($urandom_range(0, 15));
            clk_step();
            e_x = 11'(m_px >>> 6);
            e_y = 11'(m_py >>> 6);
            n_checks++;
            if ({moving, ballLost, topLeftX, topLeftY} !==
                {(m_mode == M_FLY), (m_mode == M_GONE), e_x, e_y}) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random_cycle%0d got mv=%b lost=%b x=%0d y=%0d want mv=%0d lost=%0d x=%0d y=%0d",
                             i, moving, ballLost, topLeftX, topLeftY,
                             (m_mode == M_FLY), (m_mode == M_GONE), e_x, e_y);
                errs++;
            end
        end
        startOfFrame = 1'b0;
        launch       = 1'b0;
        collision    = 1'b0;
        hitEdgeCode  = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_launch();
        test_top_bounce();
        test_repeated_hits();
        test_coincident();
        test_loss();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
